gray_histogram: RTL and testbench

Streaming grayscale-histogram engine for the image-processing pipeline (sibling of the gray and binarization blocks). After reset it reads a V_SIZE×H_SIZE RGB frame once through the shared frame-buffer read port (address out, pixel back one cycle later), converts each pixel to an 8-bit gray level and counts occurrences in 256 bins. When the last pixel is counted it raises `done` and holds the histogram for readout until the next reset.

---
 rtl/gray_histogram.sv | 134 +++++++++++++
 tb/tb_gray_histogram.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_histogram.sv
// Streaming 256-bin grayscale histogram: reads one V_SIZE x H_SIZE RGB frame after reset and holds the counts.
// Optional macro GRAY_HIST_LUMA_EN selects luma weighting; without it the red channel is taken as the gray level.
module gray_histogram #(
    parameter int V_SIZE = 50,
    parameter int H_SIZE = 50,
    localparam int N      = V_SIZE * H_SIZE,
    localparam int ADDR_W = $clog2(N),
    localparam int CNT_W  = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              rd_pixel,
    output logic [ADDR_W-1:0] addr_pixel,
    input  logic              pixel_val,
    input  logic [23:0]       pixel_in,
    input  logic [7:0]        hist_addr,
    output logic [CNT_W-1:0]  hist_data,
    output logic              done
);

    typedef enum logic [1:0] {READ, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] issue_q, issue_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic [CNT_W-1:0]  rxCnt_q, rxCnt_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  hist_q;
    logic [CNT_W-1:0]  bins_q [256];

    logic [7:0] grayLevel;
    logic       countEn;
    logic       lastPixel;

`ifdef GRAY_HIST_LUMA_EN
    logic [15:0] lumaSum;
    assign lumaSum   = 16'd77  * {8'd0, pixel_in[23:16]}
                     + 16'd150 * {8'd0, pixel_in[15:8]}
                     + 16'd29  * {8'd0, pixel_in[7:0]};
    assign grayLevel = 8'(lumaSum >> 8);
`else
    // Upstream guarantees R=G=B here, so green and blue carry no extra information.
    logic unusedGreenBlue;
    assign unusedGreenBlue = ^pixel_in[15:0];
    assign grayLevel       = pixel_in[23:16];
`endif

    assign countEn   = pixel_val && (state_q != DONE);
    assign lastPixel = countEn && (rxCnt_q == CNT_W'(N - 1));

    always_comb begin
        state_d = state_q;
        issue_d = issue_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;
        rxCnt_d = rxCnt_q;
        done_d  = done_q;

        if (countEn) begin
            rxCnt_d = rxCnt_q + CNT_W'(1);
        end

        unique case (state_q)
            READ: begin
                rd_d    = 1'b1;
                addr_d  = issue_q;
                issue_d = issue_q + ADDR_W'(1);
                if (issue_q == ADDR_W'(N - 1)) begin
                    state_d = DRAIN;
                end
                if (lastPixel) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DRAIN: begin
                if (lastPixel) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = READ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= READ;
            issue_q <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            rxCnt_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            rxCnt_q <= rxCnt_d;
            done_q  <= done_d;
        end
    end

    // Read-modify-write completes in one cycle, so back-to-back hits on one bin never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                bins_q[i] <= '0;
            end
        end else if (countEn) begin
            bins_q[grayLevel] <= bins_q[grayLevel] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= bins_q[hist_addr];
        end
    end

    assign rd_pixel   = rd_q;
    assign addr_pixel = addr_q;
    assign hist_data  = hist_q;
    assign done       = done_q;

endmodule

// File: tb/tb_gray_histogram.sv
// Scoreboard bench for gray_histogram: a modelled frame-buffer source feeds frames, a reference
// histogram is built from the gray-level rule, and a monitor checks readouts, addresses and done timing.
module tb_gray_histogram;

    localparam int V_SIZE = 50;
    localparam int H_SIZE = 50;
    localparam int N      = V_SIZE * H_SIZE;
    localparam int ADDR_W = $clog2(N);
    localparam int CNT_W  = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rd_pixel;
    logic [ADDR_W-1:0] addr_pixel;
    logic              pixel_val = 1'b0;
    logic [23:0]       pixel_in = '0;
    logic [7:0]        hist_addr = '0;
    logic [CNT_W-1:0]  hist_data;
    logic              done;

    gray_histogram #(.V_SIZE(V_SIZE), .H_SIZE(H_SIZE)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_pixel  (rd_pixel),
        .addr_pixel(addr_pixel),
        .pixel_val (pixel_val),
        .pixel_in  (pixel_in),
        .hist_addr (hist_addr),
        .hist_data (hist_data),
        .done      (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [23:0] frame [N];
    int expHist [256];
    int expQ[$];
    int binQ[$];
    int reqQ[$];
    int availQ[$];

    logic histReq = 1'b0;
    logic reqPend = 1'b0;
    int cycle = 0;
    int latency = 1;
    int gapPct = 0;
    bit junkAfterDone = 1'b0;
    int pixSent = 0;
    int lastEdge = 0;
    int doneEdge = 0;
    bit doneSeen = 1'b0;
    int expIssue = 0;

    function automatic int grayOf(logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
`ifdef GRAY_HIST_LUMA_EN
        return (77 * r + 150 * g + 29 * b) / 256;
`else
        return r + 0 * (g + b);
`endif
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cycle);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) cycle <= 0;
        else       cycle <= cycle + 1;
    end

    always @(posedge clk) reqPend <= histReq;

    // Monitor: scoreboard pops, request sequence, done timing; also records requests for the source.
    always @(negedge clk) begin
        if (reqPend) begin
            if (expQ.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                int want, bin;
                want = expQ.pop_front();
                bin  = binQ.pop_front();
                check($sformatf("bin%0d", bin), int'(hist_data), want);
            end
        end
        if (!reset) begin
            if (cycle >= 1 && cycle <= N + 1)
                check("rd_pixel", int'(rd_pixel), (cycle <= N) ? 1 : 0);
            if (done)
                check("rd_after_done", int'(rd_pixel), 0);
            if (rd_pixel) begin
                check("addr_pixel", int'(addr_pixel), expIssue);
                expIssue++;
                reqQ.push_back(int'(addr_pixel));
                availQ.push_back(cycle + latency);
            end
            if (done && !doneSeen) begin
                doneSeen = 1'b1;
                doneEdge = cycle;
            end
        end else begin
            expIssue = 0;
            doneSeen = 1'b0;
        end
    end

    // Frame-buffer source: fixed latency, random gaps, optional junk after done.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                pixel_val = 1'b0;
                reqQ.delete();
                availQ.delete();
                pixSent = 0;
            end else if (availQ.size() > 0 && availQ[0] <= cycle &&
                         int'($urandom_range(99)) >= gapPct) begin
                int a;
                a = reqQ.pop_front();
                void'(availQ.pop_front());
                pixel_val = 1'b1;
                pixel_in  = frame[a];
                pixSent++;
                if (pixSent == N) lastEdge = cycle + 1;
            end else if (junkAfterDone && done) begin
                pixel_val = 1'($urandom_range(1));
                pixel_in  = 24'($urandom);
            end else begin
                pixel_val = 1'b0;
                pixel_in  = 24'($urandom);
            end
        end
    end

    task automatic applyStimulus(input int kind);
        for (int i = 0; i < N; i++) begin
            logic [7:0] v;
            v = 8'(i % 256);
            case (kind)
                0: frame[i] = 24'h808080;
                1: frame[i] = 24'h000000;
                2: frame[i] = 24'hFFFFFF;
                3: frame[i] = 24'hFF0000;
                4: frame[i] = {v, v, v};
                default: begin
`ifdef GRAY_HIST_LUMA_EN
                    frame[i] = 24'($urandom);
`else
                    v = 8'($urandom_range(255));
                    frame[i] = {v, v, v};
`endif
                end
            endcase
        end
        for (int b = 0; b < 256; b++) expHist[b] = 0;
        for (int i = 0; i < N; i++) expHist[grayOf(frame[i])]++;
    endtask

    task automatic checkOutput(input bit useModel);
        for (int a = 0; a < 256; a++) begin
            @(posedge clk);
            #1;
            hist_addr = 8'(a);
            histReq   = 1'b1;
            expQ.push_back(useModel ? expHist[a] : 0);
            binQ.push_back(a);
        end
        @(posedge clk);
        #1;
        histReq = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic startFrame();
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic runFrame(input int kind, input int lat, input int gap,
                            input bit junk, input int abortAt);
        int k;
        latency       = lat;
        gapPct        = gap;
        junkAfterDone = junk;
        applyStimulus(kind);
        startFrame();
        if (abortAt > 0) begin
            for (k = 0; k < 20000 && pixSent < abortAt; k++) @(posedge clk);
            check("abort_reached", int'(pixSent >= abortAt), 1);
            @(negedge clk);
            #2 reset = 1'b1;
            checkOutput(1'b0);
            @(negedge clk);
            #2 reset = 1'b0;
        end
        for (k = 0; k < 30000 && !done; k++) @(posedge clk);
        check("done_timeout", int'(done), 1);
        @(negedge clk);
        check("done_edge", doneEdge, lastEdge);
        if (lat == 1 && gap == 0)
            check("done_edge_n2", doneEdge, N + 2);
        repeat (5) @(posedge clk);
        checkOutput(1'b1);
        check("pixels_sent", pixSent, N);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rd_pixel", int'(rd_pixel), 0);
        check("reset_addr", int'(addr_pixel), 0);
        check("reset_hist_data", int'(hist_data), 0);
        check("reset_done", int'(done), 0);

        runFrame(0, 1, 0, 1'b0, 0);
        runFrame(1, 1, 0, 1'b0, 0);
        runFrame(2, 1, 0, 1'b0, 0);
        runFrame(3, 1, 0, 1'b0, 0);
        runFrame(4, 1, 0, 1'b0, 0);
        runFrame(4, 1, 0, 1'b0, 1000);
        runFrame(5, 3, 30, 1'b1, 0);
        runFrame(4, 2, 50, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
